proc_control_fsm: RTL and testbench

//  Control unit for the 9-bit simple processor. Fetches an instruction word from DIN into IR.

---
 rtl/proc_pkg.sv | 32 +++
 rtl/proc_control_fsm_dec3to8.sv | 18 +
 rtl/proc_control_fsm.sv | 132 +++++++++++++
 tb/tb_proc_control_fsm.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/proc_pkg.sv
// Shared types and constants for the 9-bit simple processor control unit.
package proc_pkg;

   localparam int DATA_W   = 9;
   localparam int NUM_REGS = 8;

   // Instruction word layout: III_XXX_YYY
   localparam int OP_HI = 8;
   localparam int OP_LO = 6;
   localparam int X_HI  = 5;
   localparam int X_LO  = 3;
   localparam int Y_HI  = 2;
   localparam int Y_LO  = 0;

   localparam logic [2:0] OP_MV  = 3'b000;
   localparam logic [2:0] OP_MVI = 3'b001;
   localparam logic [2:0] OP_ADD = 3'b010;
   localparam logic [2:0] OP_SUB = 3'b011;

   typedef enum logic [1:0] {
      T0 = 2'd0,
      T1 = 2'd1,
      T2 = 2'd2,
      T3 = 2'd3
   } state_t;

   // Extract the opcode field from an instruction word.
   function automatic logic [2:0] ir_op(input logic [DATA_W-1:0] ir);
      return ir[OP_HI:OP_LO];
   endfunction

endpackage

// File: rtl/proc_control_fsm_dec3to8.sv
// 3-bit index to one-hot 8 decoder with enable; output is all-zero when disabled.
module dec3to8 (
   input  logic [2:0] idx_i,
   input  logic       en_i,
   output logic [7:0] onehot_o
);

   // Drive a single bit selected by the index, or nothing when disabled.
   always_comb begin
      onehot_o = 8'h00;
      if (en_i) begin
         onehot_o[idx_i] = 1'b1;
      end else begin
         onehot_o = 8'h00;
      end
   end

endmodule

// File: rtl/proc_control_fsm.sv
// Control unit for the 9-bit simple processor: fetches an instruction into IR and
// sequences the shared bus, register enables, A/G registers and the adder/subtractor.
module proc_control_fsm
   import proc_pkg::*;
(
   input  logic              clk,
   input  logic              resetn,
   input  logic              run,
   input  logic [DATA_W-1:0] DIN,
   output logic [DATA_W-1:0] IR,
   output logic [7:0]        Rout,
   output logic              DINout,
   output logic              Gout,
   output logic [7:0]        Rin,
   output logic              Ain,
   output logic              Gin,
   output logic              AddSub,
   output logic              Done
);

   state_t            state_q, state_d;
   logic [DATA_W-1:0] ir_q, ir_d;

   logic       rout_x_s, rout_y_s, rin_x_s;
   logic       dinout_s, gout_s, ain_s, gin_s, addsub_s, done_s;
   logic [7:0] x_sel_s, y_sel_s;
   logic [2:0] op_s;

   assign op_s = ir_op(ir_q);

   // Next-state, IR capture and per-state control strobes.
   always_comb begin
      state_d  = state_q;
      ir_d     = ir_q;
      rout_x_s = 1'b0;
      rout_y_s = 1'b0;
      rin_x_s  = 1'b0;
      dinout_s = 1'b0;
      gout_s   = 1'b0;
      ain_s    = 1'b0;
      gin_s    = 1'b0;
      addsub_s = 1'b0;
      done_s   = 1'b0;
      case (state_q)
         T0: begin
            if (run) begin
               ir_d    = DIN;
               state_d = T1;
            end else begin
               state_d = T0;
            end
         end
         T1: begin
            case (op_s)
               OP_MV: begin
                  rout_y_s = 1'b1;
                  rin_x_s  = 1'b1;
                  done_s   = 1'b1;
                  state_d  = T0;
               end
               OP_MVI: begin
                  dinout_s = 1'b1;
                  rin_x_s  = 1'b1;
                  done_s   = 1'b1;
                  state_d  = T0;
               end
               OP_ADD, OP_SUB: begin
                  rout_x_s = 1'b1;
                  ain_s    = 1'b1;
                  state_d  = T2;
               end
               default: begin
                  // Undefined opcodes retire as a NOP with no bus activity.
                  done_s  = 1'b1;
                  state_d = T0;
               end
            endcase
         end
         T2: begin
            rout_y_s = 1'b1;
            gin_s    = 1'b1;
            addsub_s = (op_s == OP_SUB);
            state_d  = T3;
         end
         T3: begin
            gout_s  = 1'b1;
            rin_x_s = 1'b1;
            done_s  = 1'b1;
            state_d = T0;
         end
         default: begin
            state_d = T0;
         end
      endcase
   end

   // State and instruction registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q <= T0;
         ir_q    <= {DATA_W{1'b0}};
      end else begin
         state_q <= state_d;
         ir_q    <= ir_d;
      end
   end

   // Decoders are disabled during reset so no register select can leak out.
   dec3to8 u_dec_x (
      .idx_i    (ir_q[X_HI:X_LO]),
      .en_i     (resetn),
      .onehot_o (x_sel_s)
   );

   dec3to8 u_dec_y (
      .idx_i    (ir_q[Y_HI:Y_LO]),
      .en_i     (resetn),
      .onehot_o (y_sel_s)
   );

   // Every output is held at zero while reset is asserted.
   assign IR     = resetn ? ir_q : {DATA_W{1'b0}};
   assign Rout   = ({8{rout_x_s}} & x_sel_s) | ({8{rout_y_s}} & y_sel_s);
   assign Rin    = {8{rin_x_s}} & x_sel_s;
   assign DINout = dinout_s & resetn;
   assign Gout   = gout_s   & resetn;
   assign Ain    = ain_s    & resetn;
   assign Gin    = gin_s    & resetn;
   assign AddSub = addsub_s & gin_s & resetn;
   assign Done   = done_s   & resetn;

endmodule

// File: tb/tb_proc_control_fsm.sv
// Self-checking bench for proc_control_fsm: table-driven cycle vectors plus a
// hand-written add sequence with run toggled randomly while the op is in flight.
module tb_proc_control_fsm;

   logic       clk;
   logic       resetn;
   logic       run;
   logic [8:0] DIN;
   logic [8:0] IR;
   logic [7:0] Rout;
   logic       DINout;
   logic       Gout;
   logic [7:0] Rin;
   logic       Ain;
   logic       Gin;
   logic       AddSub;
   logic       Done;

   int n_checks;
   int n_fail;

   // Packed outputs: {IR[8:0], Rout[7:0], Rin[7:0], DINout, Gout, Ain, Gin, AddSub, Done}
   typedef struct {
      logic        rstn;
      logic        run;
      logic [8:0]  din;
      logic [30:0] exp;
   } vec_t;

   vec_t        vecs[19];
   logic [30:0] sb_q[$];

   proc_control_fsm dut (
      .clk    (clk),
      .resetn (resetn),
      .run    (run),
      .DIN    (DIN),
      .IR     (IR),
      .Rout   (Rout),
      .DINout (DINout),
      .Gout   (Gout),
      .Rin    (Rin),
      .Ain    (Ain),
      .Gin    (Gin),
      .AddSub (AddSub),
      .Done   (Done)
   );

   always #5 clk = ~clk;

   function automatic logic [30:0] o(input logic [8:0] ir, input logic [7:0] rout,
                                     input logic [7:0] rin, input logic dinout,
                                     input logic gout, input logic ain, input logic gin,
                                     input logic addsub, input logic done);
      return {ir, rout, rin, dinout, gout, ain, gin, addsub, done};
   endfunction

   function automatic vec_t v(input logic rstn, input logic r, input logic [8:0] d,
                              input logic [30:0] e);
      vec_t t;
      t.rstn = rstn;
      t.run  = r;
      t.din  = d;
      t.exp  = e;
      return t;
   endfunction

   // Drive one cycle of inputs just after the rising edge, queue the expectation,
   // then sample at the falling edge and compare against the queue head.
   task automatic drive_cycle(input logic rstn, input logic r, input logic [8:0] d,
                              input logic [30:0] e, input int tag);
      logic [30:0] act;
      logic [30:0] want;
      logic [9:0]  srcs;
      @(posedge clk);
      #1;
      resetn = rstn;
      run    = r;
      DIN    = d;
      sb_q.push_back(e);
      @(negedge clk);
      act = {IR, Rout, Rin, DINout, Gout, Ain, Gin, AddSub, Done};
      n_checks++;
      if (sb_q.size() == 0) begin
         n_fail++;
         $display("FAIL step%0d: scoreboard empty, actual %h", tag, act);
      end else begin
         want = sb_q.pop_front();
         if (act !== want) begin
            n_fail++;
            $display("FAIL step%0d: outputs actual %h required %h", tag, act, want);
         end
      end
      srcs = {Rout, DINout, Gout};
      n_checks++;
      if ($countones(srcs) > 1 || $countones(Rin) > 1) begin
         n_fail++;
         $display("FAIL onehot%0d: bus sources %b Rin %b, required at most one each",
                  tag, srcs, Rin);
      end
   endtask

   initial begin
      logic [30:0] zero;
      clk      = 1'b0;
      resetn   = 1'b0;
      run      = 1'b0;
      DIN      = 9'h000;
      n_checks = 0;
      n_fail   = 0;
      zero     = 31'd0;

      // Reset held 3 cycles with run high, then mvi R5, sub R1,R6, mv R3,R3,
      // undefined 111, and add R2,R2 aborted by reset in T2.
      vecs[0]  = v(1'b0, 1'b1, 9'h1FF, zero);
      vecs[1]  = v(1'b0, 1'b1, 9'h1FF, zero);
      vecs[2]  = v(1'b0, 1'b1, 9'h1FF, zero);
      vecs[3]  = v(1'b1, 1'b0, 9'h1FF, zero);
      vecs[4]  = v(1'b1, 1'b1, 9'b001_101_000, zero);
      vecs[5]  = v(1'b1, 1'b0, 9'h1A5,
                   o(9'h068, 8'h00, 8'h20, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
      vecs[6]  = v(1'b1, 1'b1, 9'b011_001_110, o(9'h068, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
      vecs[7]  = v(1'b1, 1'b0, 9'h000,
                   o(9'h0CE, 8'h02, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
      vecs[8]  = v(1'b1, 1'b1, 9'h1FF,
                   o(9'h0CE, 8'h40, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0));
      vecs[9]  = v(1'b1, 1'b1, 9'h155,
                   o(9'h0CE, 8'h00, 8'h02, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1));
      vecs[10] = v(1'b1, 1'b1, 9'b000_011_011, o(9'h0CE, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
      vecs[11] = v(1'b1, 1'b1, 9'b111_010_001,
                   o(9'h01B, 8'h08, 8'h08, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
      vecs[12] = v(1'b1, 1'b1, 9'b111_010_001, o(9'h01B, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
      vecs[13] = v(1'b1, 1'b1, 9'b010_010_010,
                   o(9'h1D1, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
      vecs[14] = v(1'b1, 1'b1, 9'b010_010_010, o(9'h1D1, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
      vecs[15] = v(1'b1, 1'b0, 9'h000,
                   o(9'h092, 8'h04, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
      vecs[16] = v(1'b0, 1'b0, 9'h000, zero);
      vecs[17] = v(1'b1, 1'b0, 9'h000, zero);
      vecs[18] = v(1'b1, 1'b0, 9'h000, zero);

      for (int i = 0; i < 19; i++) begin
         drive_cycle(vecs[i].rstn, vecs[i].run, vecs[i].din, vecs[i].exp, i);
      end

      // add R7,R0 with run toggled randomly while the instruction is in flight.
      drive_cycle(1'b1, 1'b1, 9'b010_111_000, zero, 100);
      drive_cycle(1'b1, 1'($urandom_range(0, 1)), 9'($urandom_range(0, 511)),
                  o(9'h0B8, 8'h80, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0), 101);
      drive_cycle(1'b1, 1'($urandom_range(0, 1)), 9'($urandom_range(0, 511)),
                  o(9'h0B8, 8'h01, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0), 102);
      drive_cycle(1'b1, 1'($urandom_range(0, 1)), 9'($urandom_range(0, 511)),
                  o(9'h0B8, 8'h00, 8'h80, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1), 103);
      drive_cycle(1'b1, 1'b0, 9'h000,
                  o(9'h0B8, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), 104);
      drive_cycle(1'b1, 1'b0, 9'h000,
                  o(9'h0B8, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), 105);

      // Nothing should be left over in the scoreboard.
      n_checks++;
      if (sb_q.size() != 0) begin
         n_fail++;
         $display("FAIL sb_drain: %0d entries left, required 0", sb_q.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
